// File: rtl/fifo_frame_reader.sv
`timescale 1ns/1ps
// Read-side controller for a 16x8 registered-read FIFO: 2-entry output buffer, valid/ready byte stream.
// Define FIFO_READER_FRAME_EN for length-prefixed framing (m_last, frames_done); otherwise bytes pass raw.
module fifo_frame_reader #(
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             fifo_empty,
    output logic             fifo_rd,
    input  logic [7:0]       fifo_dout,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [7:0]       m_data,
    output logic             m_last,
    output logic [CNT_W-1:0] frames_done
);

    logic       inflight;
    logic [1:0] occ;
    logic       rd_ptr;
    logic       wr_ptr;
    logic [7:0] buf_data [2];
    logic       buf_last [2];
    logic       pop;
    logic       push;
    logic       push_last;
    logic [2:0] committed;

    assign pop = m_valid && m_ready;

    // Buffer slots still spoken for once this cycle's pop and in-flight capture have settled.
    assign committed = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd   = rst_n && !fifo_empty && (committed < 3'd2);

    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            inflight <= 1'b0;
        end else begin
            inflight <= fifo_rd;
        end
    end

    // NOTE: the two buffer entries are reset so m_data reads 0 out of reset; a deep RAM would not be.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            occ    <= 2'd0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                buf_data[i] <= 8'h00;
                buf_last[i] <= 1'b0;
            end
        end else begin
            if (push) begin
                buf_data[wr_ptr] <= fifo_dout;
                buf_last[wr_ptr] <= push_last;
                wr_ptr           <= !wr_ptr;
            end
            if (pop) begin
                rd_ptr <= !rd_ptr;
            end
            occ <= occ + {1'b0, push} - {1'b0, pop};
        end
    end

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_data[rd_ptr];
    assign m_last  = buf_last[rd_ptr];

`ifdef FIFO_READER_FRAME_EN
    typedef enum logic {ST_HDR, ST_PAY} state_t;

    state_t     state;
    state_t     state_nxt;
    logic [7:0] rem;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_HDR;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: defaults come first so every path assigns and no latch is inferred.
    always_comb begin
        state_nxt = state;
        if (inflight) begin
            case (state)
                ST_HDR:  if (fifo_dout != 8'h00) state_nxt = ST_PAY;
                ST_PAY:  if (rem == 8'd1)        state_nxt = ST_HDR;
                default: state_nxt = ST_HDR;
            endcase
        end
    end

    always_comb begin
        push      = 1'b0;
        push_last = 1'b0;
        if (state == ST_PAY) begin
            push      = inflight;
            push_last = (rem == 8'd1);
        end
    end

    // A zero header also lands here; it is harmless since the FSM stays in HDR.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            rem <= 8'd0;
        end else if (inflight) begin
            if (state == ST_HDR) begin
                rem <= fifo_dout;
            end else begin
                rem <= rem - 8'd1;
            end
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            frames_done <= '0;
        end else if (pop && m_last) begin
            frames_done <= frames_done + CNT_W'(1);
        end
    end
`else
    assign push        = inflight;
    assign push_last   = 1'b0;
    assign frames_done = '0;
`endif

endmodule

// File: tb/tb_fifo_frame_reader.sv
`timescale 1ns/1ps
// Self-checking bench for fifo_frame_reader: FIFO model, beat monitor and a frame-parsing reference model.
module tb_fifo_frame_reader;

`ifdef FIFO_READER_FRAME_EN
    localparam bit FRAME_EN = 1'b1;
`else
    localparam bit FRAME_EN = 1'b0;
`endif
    localparam int CNT_W = 16;

    typedef struct {
        logic [7:0] data;
        logic       last;
        int         src;
    } beat_t;
    typedef logic [7:0] bytes_t [$];
    typedef beat_t      beats_t [$];

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             fifo_empty;
    logic             fifo_rd;
    logic [7:0]       fifo_dout = 8'h00;
    logic             m_valid;
    logic             m_ready = 1'b0;
    logic [7:0]       m_data;
    logic             m_last;
    logic [CNT_W-1:0] frames_done;

    int errors = 0;
    int checks = 0;
    int exp_frames = 0;

    fifo_frame_reader #(.CNT_W(CNT_W)) dut (
        .clock      (clock),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .fifo_dout  (fifo_dout),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .m_last     (m_last),
        .frames_done(frames_done)
    );

    always #5 clock = ~clock;

    // 16-deep registered-read FIFO driven through a write port.
    logic [7:0] fq [$];
    int         fifo_cnt = 0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       fifo_clr = 1'b0;

    assign fifo_empty = (fifo_cnt == 0);

    always @(posedge clock) begin
        if (fifo_clr) begin
            fq.delete();
        end else begin
            if (fifo_rd && fq.size() != 0) fifo_dout <= fq.pop_front();
            if (wr_en && fq.size() < 16) fq.push_back(wr_data);
        end
        fifo_cnt <= fq.size();
    end

    // Monitor: records read strobes and accepted beats with their cycle numbers.
    int         cycle = 0;
    int         rd_cyc [$];
    int         beat_cyc [$];
    logic [8:0] obs [$];
    int         rd_empty_viol = 0;
    int         stab_viol = 0;
    logic       prev_stall = 1'b0;
    logic [8:0] prev_beat = 9'h000;

    always @(negedge clock) begin
        if (rst_n) begin
            if (fifo_rd) begin
                rd_cyc.push_back(cycle);
                if (fifo_empty) rd_empty_viol++;
            end
            if (prev_stall && (!m_valid || {m_last, m_data} !== prev_beat)) stab_viol++;
            if (m_valid && m_ready) begin
                obs.push_back({m_last, m_data});
                beat_cyc.push_back(cycle);
            end
            prev_stall = m_valid && !m_ready;
            prev_beat  = {m_last, m_data};
        end else begin
            prev_stall = 1'b0;
        end
        cycle++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog expired");
    end

    // Reference model: parse the byte stream into expected output beats.
    function automatic void model(input bytes_t s, output beats_t e, output int nlast);
        int    rem;
        beat_t b;
        rem   = 0;
        nlast = 0;
        e     = {};
        foreach (s[i]) begin
            if (!FRAME_EN) begin
                b.data = s[i]; b.last = 1'b0; b.src = i;
                e.push_back(b);
            end else if (rem == 0) begin
                rem = int'(s[i]);
            end else begin
                b.data = s[i]; b.last = (rem == 1); b.src = i;
                e.push_back(b);
                rem--;
                if (b.last) nlast++;
            end
        end
    endfunction

    function automatic logic [8:0] obs_at(input int i);
        return (i < obs.size()) ? obs[i] : 9'h1FF;
    endfunction

    function automatic int lat_of(input int bi, input int ri);
        if (bi >= beat_cyc.size() || ri >= rd_cyc.size()) return -1;
        return beat_cyc[bi] - rd_cyc[ri];
    endfunction

    task automatic push_bytes(input bytes_t s, input int gap_pct);
        int i;
        i = 0;
        while (i < s.size()) begin
            @(posedge clock); #1;
            if (fifo_cnt < 16 && int'($urandom_range(99)) >= gap_pct) begin
                wr_en = 1'b1; wr_data = s[i]; i++;
            end else begin
                wr_en = 1'b0;
            end
        end
        @(posedge clock); #1;
        wr_en = 1'b0;
    endtask

    task automatic wait_drain(output bit ok);
        int idle;
        idle = 0;
        ok   = 1'b0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clock);
            if (fifo_cnt == 0 && !fifo_rd && !m_valid) idle++; else idle = 0;
            if (idle >= 3) ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        m_ready = 1'b0;
        repeat (2) @(negedge clock);
        checks++;
        if ({fifo_rd, m_valid, m_data, m_last} !== 11'd0 || frames_done !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got rd=%b v=%b d=%h l=%b fd=%0d want all 0",
                     fifo_rd, m_valid, m_data, m_last, frames_done);
        end
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(negedge clock);
        checks++;
        if (m_valid !== 1'b0 || fifo_rd !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: got v=%b rd=%b want 0 0", m_valid, fifo_rd);
        end
    endtask

    task automatic test_basic();
        bytes_t s; beats_t e; int nl, bo, bb, br; bit ok;
        s  = {8'h03, 8'hAA, 8'hBB, 8'hCC};
        bo = obs.size(); bb = beat_cyc.size(); br = rd_cyc.size();
        m_ready = 1'b1;
        push_bytes(s, 0);
        wait_drain(ok);
        model(s, e, nl);
        exp_frames += nl;
        checks++;
        if (!ok) begin errors++; $display("FAIL basic_drain: got timeout want idle"); end
        checks++;
        if (obs.size() - bo != e.size()) begin
            errors++; $display("FAIL basic_count: got %0d want %0d", obs.size() - bo, e.size());
        end
        foreach (e[i]) begin
            checks++;
            if (obs_at(bo + i) !== {e[i].last, e[i].data}) begin
                errors++; $display("FAIL basic_beat%0d: got %h want %h", i, obs_at(bo + i), {e[i].last, e[i].data});
            end
            checks++;
            if (lat_of(bb + i, br + e[i].src) != 2) begin
                errors++; $display("FAIL basic_latency%0d: got %0d want 2", i, lat_of(bb + i, br + e[i].src));
            end
            if (i > 0) begin
                checks++;
                if (lat_of(bb + i, 0) - lat_of(bb + i - 1, 0) != 1) begin
                    errors++; $display("FAIL basic_gap%0d: got %0d want 1", i, lat_of(bb + i, 0) - lat_of(bb + i - 1, 0));
                end
            end
        end
        checks++;
        if (frames_done !== CNT_W'(exp_frames)) begin
            errors++; $display("FAIL basic_frames: got %0d want %0d", frames_done, exp_frames);
        end
    endtask

    task automatic test_backpressure();
        bytes_t s; beats_t e; int nl, bo, bb, br; bit ok;
        s  = {8'h03, 8'hAA, 8'hBB, 8'hCC};
        bo = obs.size(); bb = beat_cyc.size(); br = rd_cyc.size();
        model(s, e, nl);
        m_ready = 1'b0;
        push_bytes(s, 0);
        repeat (3) @(negedge clock);
        checks++;
        if (rd_cyc.size() - br != e[1].src + 1) begin
            errors++; $display("FAIL bp_rd_pulses: got %0d want %0d", rd_cyc.size() - br, e[1].src + 1);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (m_valid !== 1'b1 || {m_last, m_data} !== {e[0].last, e[0].data}) begin
                errors++; $display("FAIL bp_hold%0d: got v=%b %h want v=1 %h", k, m_valid, {m_last, m_data}, {e[0].last, e[0].data});
            end
            @(negedge clock);
        end
        @(posedge clock); #1;
        m_ready = 1'b1;
        wait_drain(ok);
        exp_frames += nl;
        checks++;
        if (!ok) begin errors++; $display("FAIL bp_drain: got timeout want idle"); end
        foreach (e[i]) begin
            checks++;
            if (obs_at(bo + i) !== {e[i].last, e[i].data}) begin
                errors++; $display("FAIL bp_beat%0d: got %h want %h", i, obs_at(bo + i), {e[i].last, e[i].data});
            end
            if (i > 0) begin
                checks++;
                if (lat_of(bb + i, 0) - lat_of(bb + i - 1, 0) != 1) begin
                    errors++; $display("FAIL bp_gap%0d: got %0d want 1", i, lat_of(bb + i, 0) - lat_of(bb + i - 1, 0));
                end
            end
        end
        checks++;
        if (stab_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d changes want 0", stab_viol); end
        checks++;
        if (frames_done !== CNT_W'(exp_frames)) begin
            errors++; $display("FAIL bp_frames: got %0d want %0d", frames_done, exp_frames);
        end
    endtask

    task automatic test_zero_len();
        bytes_t s; beats_t e; int nl, bo, bb, br; bit ok;
        s  = {8'h00, 8'h01, 8'h55};
        bo = obs.size(); bb = beat_cyc.size(); br = rd_cyc.size();
        m_ready = 1'b1;
        push_bytes(s, 0);
        wait_drain(ok);
        model(s, e, nl);
        exp_frames += nl;
        checks++;
        if (!ok || obs.size() - bo != e.size()) begin
            errors++; $display("FAIL zero_count: got %0d want %0d", obs.size() - bo, e.size());
        end
        foreach (e[i]) begin
            checks++;
            if (obs_at(bo + i) !== {e[i].last, e[i].data} || lat_of(bb + i, br + e[i].src) != 2) begin
                errors++; $display("FAIL zero_beat%0d: got %h lat %0d want %h lat 2", i, obs_at(bo + i),
                                   lat_of(bb + i, br + e[i].src), {e[i].last, e[i].data});
            end
        end
        checks++;
        if (frames_done !== CNT_W'(exp_frames)) begin
            errors++; $display("FAIL zero_frames: got %0d want %0d", frames_done, exp_frames);
        end
    endtask

    task automatic test_stall_mid_frame();
        bytes_t s, s1, s2; beats_t e; int nl, bo, bb, br, r0; bit ok;
        s1 = {8'h02, 8'hAA};
        s2 = {8'h66};
        s  = {s1, s2};
        bo = obs.size(); bb = beat_cyc.size(); br = rd_cyc.size();
        m_ready = 1'b1;
        push_bytes(s1, 0);
        repeat (3) @(negedge clock);
        r0 = rd_cyc.size();
        checks++;
        if (r0 - br != 2) begin errors++; $display("FAIL stall_reads: got %0d want 2", r0 - br); end
        repeat (10) @(negedge clock);
        checks++;
        if (rd_cyc.size() != r0) begin
            errors++; $display("FAIL stall_no_rd: got %0d pulses want 0", rd_cyc.size() - r0);
        end
        push_bytes(s2, 0);
        wait_drain(ok);
        model(s, e, nl);
        exp_frames += nl;
        checks++;
        if (!ok || obs.size() - bo != e.size()) begin
            errors++; $display("FAIL stall_count: got %0d want %0d", obs.size() - bo, e.size());
        end
        foreach (e[i]) begin
            checks++;
            if (obs_at(bo + i) !== {e[i].last, e[i].data} || lat_of(bb + i, br + e[i].src) != 2) begin
                errors++; $display("FAIL stall_beat%0d: got %h lat %0d want %h lat 2", i, obs_at(bo + i),
                                   lat_of(bb + i, br + e[i].src), {e[i].last, e[i].data});
            end
        end
        checks++;
        if (frames_done !== CNT_W'(exp_frames) || rd_empty_viol != 0) begin
            errors++; $display("FAIL stall_frames: got %0d rd_on_empty=%0d want %0d rd_on_empty=0",
                               frames_done, rd_empty_viol, exp_frames);
        end
    endtask

    task automatic test_random();
        bytes_t s; beats_t e; int nl, bo, len, bad; bit ok, feed_done;
        s = {};
        for (int f = 0; f < 24; f++) begin
            len = (f == 11) ? 255 : (($urandom_range(9) == 0) ? 0 : int'($urandom_range(1, 8)));
            s.push_back(len[7:0]);
            repeat (len) s.push_back(8'($urandom_range(255)));
        end
        bo = obs.size();
        feed_done = 1'b0;
        fork
            begin
                push_bytes(s, 30);
                feed_done = 1'b1;
            end
            begin
                while (!feed_done) begin
                    @(posedge clock); #1;
                    m_ready = ($urandom_range(3) != 0);
                end
            end
        join
        m_ready = 1'b1;
        wait_drain(ok);
        model(s, e, nl);
        exp_frames += nl;
        checks++;
        if (!ok || obs.size() - bo != e.size()) begin
            errors++; $display("FAIL rand_count: got %0d want %0d", obs.size() - bo, e.size());
        end
        bad = 0;
        foreach (e[i]) begin
            checks++;
            if (obs_at(bo + i) !== {e[i].last, e[i].data}) begin
                errors++;
                if (bad < 5) $display("FAIL rand_beat%0d: got %h want %h", i, obs_at(bo + i), {e[i].last, e[i].data});
                bad++;
            end
        end
        checks++;
        if (stab_viol != 0 || rd_empty_viol != 0) begin
            errors++; $display("FAIL rand_protocol: got unstable=%0d rd_on_empty=%0d want 0 0", stab_viol, rd_empty_viol);
        end
        checks++;
        if (frames_done !== CNT_W'(exp_frames)) begin
            errors++; $display("FAIL rand_frames: got %0d want %0d", frames_done, exp_frames);
        end
    endtask

    task automatic test_reset_mid_frame();
        bytes_t s, s2; beats_t e; int nl, bo, bb, br; bit ok;
        s  = {8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        s2 = {8'h01, 8'h77};
        m_ready = 1'b0;
        push_bytes(s, 0);
        repeat (2) @(negedge clock);
        @(posedge clock); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({fifo_rd, m_valid, m_data, m_last} !== 11'd0 || frames_done !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got rd=%b v=%b d=%h l=%b fd=%0d want all 0",
                     fifo_rd, m_valid, m_data, m_last, frames_done);
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            checks++;
            if (fifo_rd !== 1'b0 || fifo_empty !== 1'b0) begin
                errors++; $display("FAIL midreset_rd%0d: got rd=%b empty=%b want 0 0", k, fifo_rd, fifo_empty);
            end
        end
        @(posedge clock); #1;
        fifo_clr = 1'b1;
        @(posedge clock); #1;
        fifo_clr   = 1'b0;
        m_ready    = 1'b1;
        rst_n      = 1'b1;
        exp_frames = 0;
        bo = obs.size(); bb = beat_cyc.size(); br = rd_cyc.size();
        push_bytes(s2, 0);
        wait_drain(ok);
        model(s2, e, nl);
        exp_frames += nl;
        checks++;
        if (!ok || obs.size() - bo != e.size()) begin
            errors++; $display("FAIL midreset_count: got %0d want %0d", obs.size() - bo, e.size());
        end
        foreach (e[i]) begin
            checks++;
            if (obs_at(bo + i) !== {e[i].last, e[i].data} || lat_of(bb + i, br + e[i].src) != 2) begin
                errors++; $display("FAIL midreset_beat%0d: got %h lat %0d want %h lat 2", i, obs_at(bo + i),
                                   lat_of(bb + i, br + e[i].src), {e[i].last, e[i].data});
            end
        end
        checks++;
        if (frames_done !== CNT_W'(exp_frames)) begin
            errors++; $display("FAIL midreset_frames: got %0d want %0d", frames_done, exp_frames);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_stall_mid_frame();
        test_random();
        test_reset_mid_frame();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
